slave_packer: RTL and testbench

Stream-receive end of the resizer: accepts S_KEEP_WIDTH-lane input beats on a valid/ready handshake, compacts kept lanes to the low positions, tags the packet end, and stores one entry per beat in a DEPTH-entry FIFO. The downstream width converter pops entries through a ready/valid entry port and uses the `underflow` flag as its empty indicator. Per-lane entry layout matches the master-side entry format, so both ends of the buffer share one lane encoding.

---
 rtl/slave_packer.sv | 109 ++++++++++
 tb/tb_slave_packer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/slave_packer.sv
// Stream-receive buffer: packs kept input lanes into one entry per beat and queues it in a DEPTH-entry FIFO.
// Build option: define SLAVE_PACKER_COMPACT_EN to compact kept lanes to the low positions; otherwise lanes stay in place.
module slave_packer #(
  parameter int S_KEEP_WIDTH    = 3,
  parameter int T_DATA_WIDTH    = 1,
  parameter int DEPTH           = 4,
  parameter int BUF_IN_ENTRY_SZ = (2 + T_DATA_WIDTH) * S_KEEP_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_valid_i,
  output logic                       s_ready_o,
  input  logic                       s_last_i,
  input  logic [S_KEEP_WIDTH-1:0]    s_keep_i,
  input  logic [T_DATA_WIDTH-1:0]    s_data_i [S_KEEP_WIDTH],
  output logic [BUF_IN_ENTRY_SZ-1:0] slave_entry_o,
  output logic                       slave_entry_valid_o,
  input  logic                       slave_entry_ready_i,
  output logic                       underflow,
  output logic                       full_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int LW = 2 + T_DATA_WIDTH;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Handshakes: a beat transfers on an edge where s_valid_i && s_ready_o; an entry
  // leaves on an edge where slave_entry_valid_o && slave_entry_ready_i. Neither side
  // may make its valid depend combinationally on the other side's ready.

  logic [BUF_IN_ENTRY_SZ-1:0] mem_q [DEPTH];
  logic [CW-1:0]              wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]              rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]              count_q, count_d;
  logic                       full_q, full_d;
  logic                       empty_q, empty_d;
  logic                       s_ready_q, s_ready_d;
  logic [BUF_IN_ENTRY_SZ-1:0] entry_d;
  logic                       wr_needed;
  logic                       wr_en;
  logic                       rd_en;

  always_comb begin
    int pos;
    int last_pos;
    entry_d  = '0;
    pos      = 0;
    last_pos = 0;
    for (int i = 0; i < S_KEEP_WIDTH; i++) begin
      if (s_keep_i[i]) begin
`ifdef SLAVE_PACKER_COMPACT_EN
        entry_d[pos*LW +: LW] = {s_data_i[i], 1'b0, 1'b1};
        last_pos = pos;
        pos = pos + 1;
`else
        entry_d[i*LW +: LW] = {s_data_i[i], 1'b0, 1'b1};
        last_pos = i;
`endif
      end
    end
    // With no kept lanes last_pos stays 0, so a bare end-of-packet marks lane 0.
    if (s_last_i) entry_d[last_pos*LW + 1] = 1'b1;
  end

  assign wr_needed = (|s_keep_i) | s_last_i;
  assign wr_en     = s_valid_i & s_ready_q & wr_needed;
  assign rd_en     = slave_entry_ready_i & ~empty_q;

  always_comb begin
    wr_ptr_d  = wr_en ? wr_ptr_q + CW'(1) : wr_ptr_q;
    rd_ptr_d  = rd_en ? rd_ptr_q + CW'(1) : rd_ptr_q;
    count_d   = wr_ptr_d - rd_ptr_d;
    empty_d   = (wr_ptr_d == rd_ptr_d);
    full_d    = (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) && (wr_ptr_d[AW] != rd_ptr_d[AW]);
    s_ready_d = ~full_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      s_ready_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      s_ready_q <= s_ready_d;
    end
  end

  // Storage is deliberately left out of reset; the output mux hides stale data while empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= entry_d;
  end

  assign slave_entry_o       = empty_q ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign slave_entry_valid_o = ~empty_q;
  assign underflow           = empty_q;
  assign full_o              = full_q;
  assign count_o             = count_q;
  assign s_ready_o           = s_ready_q;

endmodule

// File: tb/tb_slave_packer.sv
// Directed bench for slave_packer with 3 lanes of 8 bits and a 4-entry FIFO.
module tb_slave_packer;

  localparam int SKW   = 3;
  localparam int TDW   = 8;
  localparam int DEPTH = 4;
  localparam int ESZ   = (2 + TDW) * SKW;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           s_valid;
  logic           s_ready;
  logic           s_last;
  logic [SKW-1:0] s_keep;
  logic [TDW-1:0] s_data [SKW];
  logic [ESZ-1:0] entry;
  logic           entry_valid;
  logic           entry_ready;
  logic           uflow;
  logic           full;
  logic [CW-1:0]  count;

  int vectors = 0;
  int errors  = 0;
  logic [ESZ-1:0] exp_q [$];

  always #5 clk = ~clk;

  slave_packer #(
    .S_KEEP_WIDTH(SKW), .T_DATA_WIDTH(TDW), .DEPTH(DEPTH), .BUF_IN_ENTRY_SZ(ESZ)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid_i(s_valid), .s_ready_o(s_ready), .s_last_i(s_last),
    .s_keep_i(s_keep), .s_data_i(s_data),
    .slave_entry_o(entry), .slave_entry_valid_o(entry_valid),
    .slave_entry_ready_i(entry_ready),
    .underflow(uflow), .full_o(full), .count_o(count)
  );

  function automatic logic [9:0] ln(input logic [7:0] d, input logic l, input logic k);
    return {d, l, k};
  endfunction

  function automatic logic [ESZ-1:0] ent(input logic [9:0] l0, input logic [9:0] l1, input logic [9:0] l2);
    return {l2, l1, l0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [2:0] k, input logic l,
                       input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
    s_valid   = v;
    s_keep    = k;
    s_last    = l;
    s_data[0] = d0;
    s_data[1] = d1;
    s_data[2] = d2;
  endtask

  task automatic idle();
    drive(1'b0, 3'b000, 1'b0, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic check_head(input string tag);
    check(tag, 32'(entry), 32'(exp_q[0]));
  endtask

  initial begin
    rst_n       = 1'b0;
    entry_ready = 1'b0;
    idle();

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_count", 32'(count), 32'd0);
    check("rst_underflow", 32'(uflow), 32'd1);
    check("rst_valid", 32'(entry_valid), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_ready", 32'(s_ready), 32'd0);
    check("rst_entry", 32'(entry), 32'd0);
    rst_n = 1'b1;
    check("ready_before_edge", 32'(s_ready), 32'd0);
    step();
    check("ready_after_edge", 32'(s_ready), 32'd1);

    // Lane packing with a dropped middle lane
    drive(1'b1, 3'b101, 1'b1, 8'h11, 8'h22, 8'h33);
    step();
    idle();
`ifdef SLAVE_PACKER_COMPACT_EN
    exp_q.push_back(ent(ln(8'h11, 1'b0, 1'b1), ln(8'h33, 1'b1, 1'b1), 10'h000));
`else
    exp_q.push_back(ent(ln(8'h11, 1'b0, 1'b1), 10'h000, ln(8'h33, 1'b1, 1'b1)));
`endif
    check("pack_underflow", 32'(uflow), 32'd0);
    check("pack_count", 32'(count), 32'd1);
    check_head("pack_entry");
    entry_ready = 1'b1;
    step();
    entry_ready = 1'b0;
    void'(exp_q.pop_front());
    check("pack_drained", 32'(uflow), 32'd1);
    check("empty_entry_zero", 32'(entry), 32'd0);

    // Zero-keep beats
    drive(1'b1, 3'b000, 1'b0, 8'hFF, 8'hFF, 8'hFF);
    step();
    check("zk_dropped_count", 32'(count), 32'd0);
    check("zk_dropped_ready", 32'(s_ready), 32'd1);
    drive(1'b1, 3'b000, 1'b1, 8'hFF, 8'hFF, 8'hFF);
    step();
    idle();
    exp_q.push_back(ent(ln(8'h00, 1'b1, 1'b0), 10'h000, 10'h000));
    check("zk_last_count", 32'(count), 32'd1);
    check_head("zk_last_entry");
    entry_ready = 1'b1;
    step();
    entry_ready = 1'b0;
    void'(exp_q.pop_front());
    check("zk_drained", 32'(count), 32'd0);

    // Fill to full, hold a fifth beat until one pop
    for (int j = 0; j < 4; j++) begin
      drive(1'b1, 3'b111, 1'b0, 8'(8'hA0 + j), 8'(8'hB0 + j), 8'(8'hC0 + j));
      exp_q.push_back(ent(ln(8'(8'hA0 + j), 1'b0, 1'b1), ln(8'(8'hB0 + j), 1'b0, 1'b1),
                          ln(8'(8'hC0 + j), 1'b0, 1'b1)));
      step();
    end
    idle();
    check("fill_count", 32'(count), 32'd4);
    check("fill_full", 32'(full), 32'd1);
    check("fill_ready", 32'(s_ready), 32'd0);
    drive(1'b1, 3'b111, 1'b1, 8'hD0, 8'hD1, 8'hD2);
    step();
    step();
    check("held_count", 32'(count), 32'd4);
    check_head("held_head");
    entry_ready = 1'b1;
    step();
    entry_ready = 1'b0;
    void'(exp_q.pop_front());
    check("pop_count", 32'(count), 32'd3);
    check("pop_full", 32'(full), 32'd0);
    check("pop_ready", 32'(s_ready), 32'd1);
    check_head("pop_head");
    step();
    idle();
    exp_q.push_back(ent(ln(8'hD0, 1'b0, 1'b1), ln(8'hD1, 1'b0, 1'b1), ln(8'hD2, 1'b1, 1'b1)));
    check("refill_count", 32'(count), 32'd4);
    check("refill_full", 32'(full), 32'd1);
    entry_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      check_head($sformatf("drain_%0d", j));
      step();
      void'(exp_q.pop_front());
    end
    entry_ready = 1'b0;
    check("drain_underflow", 32'(uflow), 32'd1);
    check("drain_count", 32'(count), 32'd0);

    // Simultaneous read and write at occupancy 2, pointers wrap
    for (int j = 0; j < 2; j++) begin
      drive(1'b1, 3'b111, 1'b0, 8'(8'h10 + j), 8'(8'h20 + j), 8'(8'h30 + j));
      exp_q.push_back(ent(ln(8'(8'h10 + j), 1'b0, 1'b1), ln(8'(8'h20 + j), 1'b0, 1'b1),
                          ln(8'(8'h30 + j), 1'b0, 1'b1)));
      step();
    end
    entry_ready = 1'b1;
    for (int j = 2; j < 8; j++) begin
      check($sformatf("rw_count_%0d", j), 32'(count), 32'd2);
      check_head($sformatf("rw_head_%0d", j));
      drive(1'b1, 3'b111, 1'b0, 8'(8'h10 + j), 8'(8'h20 + j), 8'(8'h30 + j));
      step();
      void'(exp_q.pop_front());
      exp_q.push_back(ent(ln(8'(8'h10 + j), 1'b0, 1'b1), ln(8'(8'h20 + j), 1'b0, 1'b1),
                          ln(8'(8'h30 + j), 1'b0, 1'b1)));
    end
    idle();
    entry_ready = 1'b0;
    check("rw_final_count", 32'(count), 32'd2);
    entry_ready = 1'b1;
    for (int j = 0; j < 2; j++) begin
      check_head($sformatf("rw_drain_%0d", j));
      step();
      void'(exp_q.pop_front());
    end
    entry_ready = 1'b0;
    check("rw_empty", 32'(uflow), 32'd1);

    // Last-lane placement for partial keeps
    drive(1'b1, 3'b110, 1'b1, 8'h55, 8'h66, 8'h77);
    step();
    drive(1'b1, 3'b010, 1'b1, 8'h88, 8'h99, 8'hAA);
    step();
    idle();
`ifdef SLAVE_PACKER_COMPACT_EN
    exp_q.push_back(ent(ln(8'h66, 1'b0, 1'b1), ln(8'h77, 1'b1, 1'b1), 10'h000));
    exp_q.push_back(ent(ln(8'h99, 1'b1, 1'b1), 10'h000, 10'h000));
`else
    exp_q.push_back(ent(10'h000, ln(8'h66, 1'b0, 1'b1), ln(8'h77, 1'b1, 1'b1)));
    exp_q.push_back(ent(10'h000, ln(8'h99, 1'b1, 1'b1), 10'h000));
`endif
    entry_ready = 1'b1;
    for (int j = 0; j < 2; j++) begin
      check_head($sformatf("last_lane_%0d", j));
      step();
      void'(exp_q.pop_front());
    end
    entry_ready = 1'b0;

    // Asynchronous reset mid-clock with entries queued
    drive(1'b1, 3'b011, 1'b0, 8'hE0, 8'hE1, 8'hE2);
    step();
    step();
    idle();
    check("pre_rst_count", 32'(count), 32'd2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_underflow", 32'(uflow), 32'd1);
    check("arst_count", 32'(count), 32'd0);
    check("arst_ready", 32'(s_ready), 32'd0);
    check("arst_entry", 32'(entry), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("release_ready_low", 32'(s_ready), 32'd0);
    @(posedge clk);
    #1;
    check("release_ready_high", 32'(s_ready), 32'd1);
    check("release_count", 32'(count), 32'd0);
    check("release_entry", 32'(entry), 32'd0);
    exp_q.delete();
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
